// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID inputs, register-file read port, EX/MEM bypass and ID/EX outputs.
interface id_stage_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    // IF/ID register contents
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_inst;
    logic             flush;

    // register-file read ports
    logic             re1;
    logic             re2;
    logic [XLEN-1:0]  r_addr1;
    logic [XLEN-1:0]  r_addr2;
    logic [XLEN-1:0]  r_data1;
    logic [XLEN-1:0]  r_data2;

    // EX-stage bypass
    logic             exf_we;
    logic [REG_W-1:0] exf_addr;
    logic [XLEN-1:0]  exf_data;
    logic             exf_is_load;

    // MEM-stage bypass
    logic             memf_we;
    logic [REG_W-1:0] memf_addr;
    logic [XLEN-1:0]  memf_data;

    // hazard request toward IF
    logic             stall_req;

    // ID/EX register contents
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic [XLEN-1:0]  ex_rs1_val;
    logic [XLEN-1:0]  ex_rs2_val;
    logic [XLEN-1:0]  ex_imm;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rd_we;

    // surrounding pipeline: feeds the decode stage and consumes its results
    modport master (
        output id_valid, id_pc, id_inst, flush,
        output r_data1, r_data2,
        output exf_we, exf_addr, exf_data, exf_is_load,
        output memf_we, memf_addr, memf_data,
        input  re1, re2, r_addr1, r_addr2, stall_req,
        input  ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7b5,
        input  ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we
    );

    // decode stage itself
    modport slave (
        input  id_valid, id_pc, id_inst, flush,
        input  r_data1, r_data2,
        input  exf_we, exf_addr, exf_data, exf_is_load,
        input  memf_we, memf_addr, memf_data,
        output re1, re2, r_addr1, r_addr2, stall_req,
        output ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7b5,
        output ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_we
    );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, operand read/forwarding, load-use detection, ID/EX register.
module id_stage (
    input logic       clk_in,
    input logic       rst_in,
    input logic       rdy_in,
    id_stage_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 7;

    localparam logic [OP_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OP_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [OP_W-1:0]  opcode;
        logic [2:0]       funct3;
        logic             funct7b5;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rd;
        logic             rd_we;
    } idex_t;

    // instruction fields
    logic [XLEN-1:0]  inst;
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [2:0]       funct3;

    assign inst   = bus.id_inst;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    // opcode class flags
    logic is_lui, is_auipc, is_jal, is_jalr, is_load, is_opimm, is_store, is_branch, is_op;
    logic legal;
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;

    // Classify the opcode; anything unrecognised leaves every flag low.
    always_comb begin
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_load   = 1'b0;
        is_opimm  = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_op     = 1'b0;
        case (opcode)
            OPC_LUI:    is_lui    = 1'b1;
            OPC_AUIPC:  is_auipc  = 1'b1;
            OPC_JAL:    is_jal    = 1'b1;
            OPC_JALR:   is_jalr   = 1'b1;
            OPC_LOAD:   is_load   = 1'b1;
            OPC_OPIMM:  is_opimm  = 1'b1;
            OPC_STORE:  is_store  = 1'b1;
            OPC_BRANCH: is_branch = 1'b1;
            OPC_OP:     is_op     = 1'b1;
            default:    ;
        endcase
    end

    assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm
                     | is_store | is_branch | is_op;
    assign uses_rs1  = is_jalr | is_load | is_opimm | is_store | is_branch | is_op;
    assign uses_rs2  = is_op | is_store | is_branch;
    assign writes_rd = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op;

    // Register-file read port requests; an unused port reads address 0.
    logic re1;
    logic re2;

    assign re1 = bus.id_valid & uses_rs1;
    assign re2 = bus.id_valid & uses_rs2;

    assign bus.re1     = re1;
    assign bus.re2     = re2;
    assign bus.r_addr1 = re1 ? XLEN'(rs1) : '0;
    assign bus.r_addr2 = re2 ? XLEN'(rs2) : '0;

    // immediate candidates for each encoding format
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Select the immediate by format; R-format and illegal opcodes give zero.
    always_comb begin
        imm = '0;
        if (is_jalr | is_load | is_opimm) begin
            imm = imm_i;
        end else if (is_store) begin
            imm = imm_s;
        end else if (is_branch) begin
            imm = imm_b;
        end else if (is_lui | is_auipc) begin
            imm = imm_u;
        end else if (is_jal) begin
            imm = imm_j;
        end
    end

    // Operand bypass: x0/unused reads are zero, EX beats MEM, MEM beats the register file.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic             en,
        input logic [REG_W-1:0] addr,
        input logic [XLEN-1:0]  rf_data,
        input logic             ex_we,
        input logic [REG_W-1:0] ex_addr,
        input logic [XLEN-1:0]  ex_data,
        input logic             mem_we,
        input logic [REG_W-1:0] mem_addr,
        input logic [XLEN-1:0]  mem_data
    );
        logic [XLEN-1:0] val;
        if (!en || addr == '0) begin
            val = '0;
        end else if (ex_we && ex_addr == addr) begin
            val = ex_data;
        end else if (mem_we && mem_addr == addr) begin
            val = mem_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rs1_val = fwd_operand(re1, rs1, bus.r_data1,
                                 bus.exf_we, bus.exf_addr, bus.exf_data,
                                 bus.memf_we, bus.memf_addr, bus.memf_data);
    assign rs2_val = fwd_operand(re2, rs2, bus.r_data2,
                                 bus.exf_we, bus.exf_addr, bus.exf_data,
                                 bus.memf_we, bus.memf_addr, bus.memf_data);

    // Load-use hazard: EX holds a load whose result this instruction needs; a flush cancels it.
    logic load_hit;
    logic stall_req;

    assign load_hit  = (re1 && rs1 == bus.exf_addr) || (re2 && rs2 == bus.exf_addr);
    assign stall_req = bus.id_valid & bus.exf_is_load & bus.exf_we
                     & (bus.exf_addr != '0) & load_hit & ~bus.flush;

    assign bus.stall_req = stall_req;

    // Decoded payload as it would enter ID/EX; rd is zeroed when nothing is written.
    idex_t idex_d;
    logic  rd_we;

    assign rd_we = writes_rd & (rd != '0);

    always_comb begin
        idex_d          = '0;
        idex_d.valid    = 1'b1;
        idex_d.pc       = bus.id_pc;
        idex_d.opcode   = opcode;
        idex_d.funct3   = funct3;
        idex_d.funct7b5 = inst[30];
        idex_d.rs1_val  = rs1_val;
        idex_d.rs2_val  = rs2_val;
        idex_d.imm      = imm;
        idex_d.rd       = rd_we ? rd : '0;
        idex_d.rd_we    = rd_we;
    end

    // Any reason not to issue turns the ID/EX slot into an all-zero bubble.
    logic bubble;

    assign bubble = bus.flush | stall_req | ~legal | ~bus.id_valid;

    // ID/EX register: reset clears, low rdy_in freezes, otherwise latch payload or bubble.
    idex_t idex_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idex_q <= '0;
        end else if (rdy_in) begin
            if (bubble) begin
                idex_q <= '0;
            end else begin
                idex_q <= idex_d;
            end
        end
    end

    assign bus.ex_valid    = idex_q.valid;
    assign bus.ex_pc       = idex_q.pc;
    assign bus.ex_opcode   = idex_q.opcode;
    assign bus.ex_funct3   = idex_q.funct3;
    assign bus.ex_funct7b5 = idex_q.funct7b5;
    assign bus.ex_rs1_val  = idex_q.rs1_val;
    assign bus.ex_rs2_val  = idex_q.rs2_val;
    assign bus.ex_imm      = idex_q.imm;
    assign bus.ex_rd       = idex_q.rd;
    assign bus.ex_rd_we    = idex_q.rd_we;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the driver queues hand-computed expectations, the monitor checks them.
module tb_id_stage;
    logic clk_in;
    logic rst_in;
    logic rdy_in;

    id_stage_if bus ();

    id_stage dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        string       nm;
        logic        stall;
        logic        re1;
        logic [31:0] a1;
        logic        re2;
        logic [31:0] a2;
        logic        v;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(input string nm, input logic stall,
                                input logic re1, input logic [31:0] a1,
                                input logic re2, input logic [31:0] a2,
                                input logic v, input logic [31:0] pc, input logic [6:0] op,
                                input logic [2:0] f3, input logic f7,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] imm, input logic [4:0] rd, input logic we);
        exp_t e;
        e.nm = nm; e.stall = stall; e.re1 = re1; e.a1 = a1; e.re2 = re2; e.a2 = a2;
        e.v = v; e.pc = pc; e.op = op; e.f3 = f3; e.f7 = f7;
        e.s1 = s1; e.s2 = s2; e.imm = imm; e.rd = rd; e.we = we;
        return e;
    endfunction

    function automatic exp_t bub(input string nm, input logic stall,
                                 input logic re1, input logic [31:0] a1,
                                 input logic re2, input logic [31:0] a2);
        return mk(nm, stall, re1, a1, re2, a2, 1'b0, 32'h0, 7'h0, 3'h0, 1'b0,
                  32'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    endfunction

    // ID/EX still holding lui x7,0xABCDE while the stage is frozen
    function automatic exp_t lui_held(input string nm, input logic stall,
                                      input logic re1, input logic [31:0] a1,
                                      input logic re2, input logic [31:0] a2);
        return mk(nm, stall, re1, a1, re2, a2, 1'b1, 32'h128, 7'h37, 3'h6, 1'b0,
                  32'h0, 32'h0, 32'hABCDE000, 5'd7, 1'b1);
    endfunction

    task automatic drv(input logic rst, input logic rdy, input logic v,
                       input logic [31:0] pc, input logic [31:0] inst, input logic fl,
                       input logic [31:0] d1, input logic [31:0] d2);
        rst_in       = rst;
        rdy_in       = rdy;
        bus.id_valid = v;
        bus.id_pc    = pc;
        bus.id_inst  = inst;
        bus.flush    = fl;
        bus.r_data1  = d1;
        bus.r_data2  = d2;
    endtask

    task automatic fw(input logic ewe, input logic [4:0] ea, input logic [31:0] ed, input logic eld,
                      input logic mwe, input logic [4:0] ma, input logic [31:0] md);
        bus.exf_we      = ewe;
        bus.exf_addr    = ea;
        bus.exf_data    = ed;
        bus.exf_is_load = eld;
        bus.memf_we     = mwe;
        bus.memf_addr   = ma;
        bus.memf_data   = md;
    endtask

    task automatic step(input exp_t e);
        q.push_back(e);
        @(negedge clk_in);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, checked just after the edge that consumed its inputs.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk(cur.nm, "stall_req", 32'(bus.stall_req),  32'(cur.stall));
                chk(cur.nm, "re1",       32'(bus.re1),        32'(cur.re1));
                chk(cur.nm, "r_addr1",   bus.r_addr1,         cur.a1);
                chk(cur.nm, "re2",       32'(bus.re2),        32'(cur.re2));
                chk(cur.nm, "r_addr2",   bus.r_addr2,         cur.a2);
                chk(cur.nm, "ex_valid",  32'(bus.ex_valid),   32'(cur.v));
                chk(cur.nm, "ex_pc",     bus.ex_pc,           cur.pc);
                chk(cur.nm, "ex_opcode", 32'(bus.ex_opcode),  32'(cur.op));
                chk(cur.nm, "ex_funct3", 32'(bus.ex_funct3),  32'(cur.f3));
                chk(cur.nm, "ex_f7b5",   32'(bus.ex_funct7b5), 32'(cur.f7));
                chk(cur.nm, "ex_rs1",    bus.ex_rs1_val,      cur.s1);
                chk(cur.nm, "ex_rs2",    bus.ex_rs2_val,      cur.s2);
                chk(cur.nm, "ex_imm",    bus.ex_imm,          cur.imm);
                chk(cur.nm, "ex_rd",     32'(bus.ex_rd),      32'(cur.rd));
                chk(cur.nm, "ex_rd_we",  32'(bus.ex_rd_we),   32'(cur.we));
            end
        end
    end

    localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] ADD_X3     = 32'h002081B3;
    localparam logic [31:0] SUB_X3     = 32'h402081B3;
    localparam logic [31:0] ADDI_X6_X5 = 32'h00128313;
    localparam logic [31:0] SW_M4      = 32'hFE20AE23;
    localparam logic [31:0] JAL_M8     = 32'hFF9FF0EF;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam logic [31:0] LUI_X7     = 32'hABCDE3B7;
    localparam logic [31:0] BNE_P8     = 32'h00209463;
    localparam logic [31:0] BEQ_M4     = 32'hFE208EE3;
    localparam logic [31:0] ILLEGAL    = 32'h0000007F;

    // Driver: apply a vector on the falling edge and queue what must be seen after the next rise.
    initial begin
        drv(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        fw(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_in);

        step(bub("reset0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        step(bub("reset1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

        drv(1'b0, 1'b1, 1'b1, 32'h100, ADDI_X1_5, 1'b0, 32'hDEAD, 32'h0);
        step(mk("addi", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100, 7'h13, 3'h0, 1'b0,
                32'h0, 32'h0, 32'h5, 5'd1, 1'b1));

        drv(1'b0, 1'b1, 1'b1, 32'h104, ADD_X3, 1'b0, 32'h11, 32'hCC);
        fw(1'b1, 5'd1, 32'hAA, 1'b0, 1'b1, 5'd1, 32'hBB);
        step(mk("fwd_ex_over_mem", 1'b0, 1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h104, 7'h33, 3'h0, 1'b0,
                32'hAA, 32'hCC, 32'h0, 5'd3, 1'b1));

        drv(1'b0, 1'b1, 1'b1, 32'h108, SUB_X3, 1'b0, 32'h77, 32'h99);
        fw(1'b1, 5'd2, 32'hCC, 1'b0, 1'b1, 5'd1, 32'hBB);
        step(mk("fwd_mix", 1'b0, 1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h108, 7'h33, 3'h0, 1'b1,
                32'hBB, 32'hCC, 32'h0, 5'd3, 1'b1));

        drv(1'b0, 1'b1, 1'b1, 32'h10C, ADDI_X6_X5, 1'b0, 32'h66, 32'h0);
        fw(1'b1, 5'd5, 32'h5555, 1'b1, 1'b0, 5'd0, 32'h0);
        step(bub("loaduse_stall", 1'b1, 1'b1, 32'h5, 1'b0, 32'h0));

        fw(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
        step(mk("loaduse_fwd", 1'b0, 1'b1, 32'h5, 1'b0, 32'h0, 1'b1, 32'h10C, 7'h13, 3'h0, 1'b0,
                32'h1234, 32'h0, 32'h1, 5'd6, 1'b1));

        drv(1'b0, 1'b1, 1'b1, 32'h110, ADDI_X1_5, 1'b0, 32'h42, 32'h0);
        fw(1'b1, 5'd0, 32'h999, 1'b1, 1'b0, 5'd0, 32'h0);
        step(mk("load_x0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h110, 7'h13, 3'h0, 1'b0,
                32'h0, 32'h0, 32'h5, 5'd1, 1'b1));

        drv(1'b0, 1'b1, 1'b1, 32'h114, ADD_X3, 1'b0, 32'h1, 32'h2);
        fw(1'b1, 5'd2, 32'h777, 1'b1, 1'b0, 5'd0, 32'h0);
        step(bub("loaduse_rs2", 1'b1, 1'b1, 32'h1, 1'b1, 32'h2));

        drv(1'b0, 1'b1, 1'b1, 32'h118, ADDI_X6_X5, 1'b1, 32'h66, 32'h0);
        fw(1'b1, 5'd5, 32'h5555, 1'b1, 1'b0, 5'd0, 32'h0);
        step(bub("flush", 1'b0, 1'b1, 32'h5, 1'b0, 32'h0));

        fw(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        drv(1'b0, 1'b1, 1'b1, 32'h11C, SW_M4, 1'b0, 32'h1000, 32'h2222);
        step(mk("sw", 1'b0, 1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h11C, 7'h23, 3'h2, 1'b1,
                32'h1000, 32'h2222, 32'hFFFFFFFC, 5'd0, 1'b0));

        drv(1'b0, 1'b1, 1'b1, 32'h120, JAL_M8, 1'b0, 32'h3333, 32'h4444);
        step(mk("jal", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h120, 7'h6F, 3'h7, 1'b1,
                32'h0, 32'h0, 32'hFFFFFFF8, 5'd1, 1'b1));

        drv(1'b0, 1'b1, 1'b1, 32'h124, NOP, 1'b0, 32'h55, 32'h0);
        step(mk("nop_rd0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h124, 7'h13, 3'h0, 1'b0,
                32'h0, 32'h0, 32'h0, 5'd0, 1'b0));

        drv(1'b0, 1'b1, 1'b1, 32'h130, BNE_P8, 1'b0, 32'h10, 32'h20);
        step(mk("bne", 1'b0, 1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h130, 7'h63, 3'h1, 1'b0,
                32'h10, 32'h20, 32'h8, 5'd0, 1'b0));

        drv(1'b0, 1'b1, 1'b1, 32'h134, BEQ_M4, 1'b0, 32'h30, 32'h40);
        step(mk("beq", 1'b0, 1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h134, 7'h63, 3'h0, 1'b1,
                32'h30, 32'h40, 32'hFFFFFFFC, 5'd0, 1'b0));

        drv(1'b0, 1'b1, 1'b1, 32'h128, LUI_X7, 1'b0, 32'h9, 32'h9);
        step(lui_held("lui", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

        drv(1'b0, 1'b0, 1'b1, 32'h300, ADDI_X6_X5, 1'b0, 32'h1, 32'h2);
        fw(1'b1, 5'd5, 32'h5555, 1'b1, 1'b0, 5'd0, 32'h0);
        step(lui_held("hold0", 1'b1, 1'b1, 32'h5, 1'b0, 32'h0));

        drv(1'b0, 1'b0, 1'b1, 32'h304, ADD_X3, 1'b0, 32'h3, 32'h4);
        fw(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd1, 32'hEE);
        step(lui_held("hold1", 1'b0, 1'b1, 32'h1, 1'b1, 32'h2));

        drv(1'b0, 1'b0, 1'b1, 32'h308, ILLEGAL, 1'b1, 32'h5, 32'h6);
        fw(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        step(lui_held("hold2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

        drv(1'b0, 1'b1, 1'b1, 32'h12C, ILLEGAL, 1'b0, 32'h5, 32'h6);
        step(bub("illegal", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

        drv(1'b0, 1'b1, 1'b0, 32'h140, ADDI_X1_5, 1'b0, 32'h5, 32'h6);
        step(bub("not_valid", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

        drv(1'b0, 1'b1, 1'b1, 32'h200, ADDI_X1_5, 1'b0, 32'h0, 32'h0);
        step(mk("pre_reset", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200, 7'h13, 3'h0, 1'b0,
                32'h0, 32'h0, 32'h5, 5'd1, 1'b1));

        drv(1'b1, 1'b1, 1'b1, 32'h204, ADDI_X1_5, 1'b0, 32'h0, 32'h0);
        step(bub("mid_reset", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0));

        drv(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(bub("idle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

        repeat (2) @(negedge clk_in);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
